// File: rtl/sigcorrelate_pkg.sv
// sigcorrelate_pkg: shared state encoding, sign-term and saturation helpers
package sigcorrelate_pkg;
  typedef enum logic [1:0] {IDLE, ACCUM, DRAIN} state_e;
  localparam int ABITS_DEF   = 10;
  localparam int ACC_MAX_DEF = (1 << (ABITS_DEF - 1)) - 1;
  localparam int ACC_MIN_DEF = -(1 << (ABITS_DEF - 1));
  function automatic logic signed [2:0] sgn(input logic x);
    return x ? 3'sd1 : -3'sd1;
  endfunction
  function automatic int acc_max(input int w);
    return (1 << (w - 1)) - 1;
  endfunction
  function automatic int acc_min(input int w);
    return -(1 << (w - 1));
  endfunction
  function automatic int sat_add(input int a, input int b, input int w);
    int s;
    s = a + b;
    return s > acc_max(w) ? acc_max(w) : s < acc_min(w) ? acc_min(w) : s;
  endfunction
endpackage

// File: rtl/sigcorrelate_term.sv
// sigcorrelate_term: one-bit a*conj(b) correlation term, each part in {-2,0,+2}
module sigcorrelate_term
  import sigcorrelate_pkg::*;
(
  input  logic              ai_i,
  input  logic              aq_i,
  input  logic              bi_i,
  input  logic              bq_i,
  output logic signed [2:0] re_o,
  output logic signed [2:0] im_o
);
  always_comb begin
    re_o = sgn(ai_i ~^ bi_i) + sgn(aq_i ~^ bq_i);
    im_o = sgn(aq_i ~^ bi_i) - sgn(ai_i ~^ bq_i);
  end
endmodule

// File: rtl/sigcorrelate.sv
// sigcorrelate: per-slot complex correlation accumulator with valid/ready drain
module sigcorrelate
  import sigcorrelate_pkg::*;
#(
  parameter int TRATE = 6,
  parameter int TBITS = 3,
  parameter int ABITS = ABITS_DEF
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    valid_i,
  input  logic                    first_i,
  input  logic                    last_i,
  input  logic [TBITS-1:0]        taddr_i,
  input  logic                    ai_i,
  input  logic                    aq_i,
  input  logic                    bi_i,
  input  logic                    bq_i,
  output logic                    busy_o,
  output logic                    drop_o,
  output logic                    valid_o,
  input  logic                    ready_i,
  output logic                    last_o,
  output logic [TBITS-1:0]        taddr_o,
  output logic signed [ABITS-1:0] re_o,
  output logic signed [ABITS-1:0] im_o,
  output logic                    sat_o
);
  localparam logic [TBITS-1:0] LAST_SLOT = TBITS'(TRATE - 1);
  state_e                  state_q, state_d;
  logic [TBITS-1:0]        rd_q, rd_d, tidx;
  logic                    drop_q;
  logic signed [ABITS-1:0] re_q [TRATE];
  logic signed [ABITS-1:0] im_q [TRATE];
  logic [TRATE-1:0]        fresh_q, sat_q;
  logic signed [2:0]       t_re, t_im;
  logic signed [ABITS-1:0] re_d, im_d;
  logic                    sat_d, drain, take, load, hs, out_en;
  int                      re_raw, im_raw, re_sum, im_sum;
  sigcorrelate_term u_term (
    .ai_i(ai_i), .aq_i(aq_i), .bi_i(bi_i), .bq_i(bq_i), .re_o(t_re), .im_o(t_im)
  );
  // Out-of-range slots are discarded entirely, including their first/last framing.
  always_comb begin
    drain  = state_q == DRAIN;
    tidx   = (int'(taddr_i) < TRATE) ? taddr_i : '0;
    take   = valid_i && (int'(taddr_i) < TRATE) && (state_q == ACCUM || (state_q == IDLE && first_i));
    load   = first_i || fresh_q[tidx];
    re_raw = int'(re_q[tidx]) + int'(t_re);
    im_raw = int'(im_q[tidx]) + int'(t_im);
    re_sum = sat_add(int'(re_q[tidx]), int'(t_re), ABITS);
    im_sum = sat_add(int'(im_q[tidx]), int'(t_im), ABITS);
    re_d   = load ? ABITS'(t_re) : ABITS'(re_sum);
    im_d   = load ? ABITS'(t_im) : ABITS'(im_sum);
    sat_d  = !load && (sat_q[tidx] || re_sum != re_raw || im_sum != im_raw);
    hs     = drain && ready_i;
    rd_d   = hs ? (rd_q == LAST_SLOT ? '0 : rd_q + 1'b1) : rd_q;
    state_d = take ? (last_i ? DRAIN : ACCUM) : (hs && rd_q == LAST_SLOT) ? IDLE : state_q;
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      rd_q    <= '0;
      drop_q  <= 1'b0;
      fresh_q <= '0;
      sat_q   <= '0;
      for (int i = 0; i < TRATE; i++) begin
        re_q[i] <= '0;
        im_q[i] <= '0;
      end
    end else begin
      state_q <= state_d;
      rd_q    <= rd_d;
      drop_q  <= drain && valid_i;
      if (take) begin
        fresh_q     <= (first_i ? {TRATE{1'b1}} : fresh_q) & ~(TRATE'(1) << tidx);
        re_q[tidx]  <= re_d;
        im_q[tidx]  <= im_d;
        sat_q[tidx] <= sat_d;
      end
    end
  end
  // Slots still marked fresh were never hit this frame and drain as zero.
  always_comb begin
    out_en  = drain && !fresh_q[rd_q];
    busy_o  = drain;
    valid_o = drain;
    drop_o  = drop_q;
    last_o  = drain && rd_q == LAST_SLOT;
    taddr_o = rd_q;
    re_o    = out_en ? re_q[rd_q] : '0;
    im_o    = out_en ? im_q[rd_q] : '0;
    sat_o   = out_en && sat_q[rd_q];
  end
endmodule
